// File: rtl/erasure_locator_seq_ctrl.sv
// Sequencer for the RS erasure locator datapath: clear, one MAC step per erasure, then stream Gamma(x) coefficients out.
// Latency: 2 cycles per erasure after a 1-cycle clear; 3 cycles per coefficient plus the downstream hold time, then a 1-cycle done.
// Backpressure: coef_valid/coef_out hold until coef_accept; RD_WAIT stalls indefinitely until dp_coef_ready.
//
// Ports:
//   clock, reset                       rising-edge clock, asynchronous active-high reset
//   start, number_of_erasures,
//   no_of_parity                       run request with erasure count N and parity count P
//   pos_rd_en/addr/data                erasure-position buffer read port (data one cycle after en)
//   dp_clear, dp_erasure_ready,
//   dp_erase_position                  datapath init and per-erasure step
//   dp_send_polyn, dp_coef_addr,
//   dp_coef, dp_coef_ready             coefficient read-back from the datapath
//   coef_out/idx/valid, coef_accept    handshaked coefficient stream to the key-equation stage
//   no_of_erasure_coefs, busy, done,
//   overflow, erasure_fail             status
//
// Optional feature macro: ERASURE_LIMIT_CHECK_EN (reject runs where the clamped N exceeds P).
module erasure_locator_seq_ctrl #(
    parameter int width           = 5,
    parameter int number_of_coefs = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] number_of_erasures,
    input  logic [width-1:0] no_of_parity,
    output logic             pos_rd_en,
    output logic [width-1:0] pos_rd_addr,
    input  logic [7:0]       pos_rd_data,
    output logic             dp_clear,
    output logic             dp_erasure_ready,
    output logic [7:0]       dp_erase_position,
    output logic             dp_send_polyn,
    output logic [width-1:0] dp_coef_addr,
    input  logic [7:0]       dp_coef,
    input  logic             dp_coef_ready,
    output logic [7:0]       coef_out,
    output logic [width-1:0] coef_idx,
    output logic             coef_valid,
    input  logic             coef_accept,
    output logic [width-1:0] no_of_erasure_coefs,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             erasure_fail
);

    // Largest erasure count the datapath can hold; also bounds every counter,
    // so k and idx never need more than width bits.
    localparam logic [width-1:0] max_n = width'(number_of_coefs - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_APPLY,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_OUT,
        ST_DONE
`ifdef ERASURE_LIMIT_CHECK_EN
        , ST_FAIL
`endif
    } state_t;

    state_t           state, state_nx;
    logic [width-1:0] n_q, n_nx;       // latched, clamped erasure count
    logic [width-1:0] k_q, k_nx;       // erasure index
    logic [width-1:0] idx_q, idx_nx;   // coefficient index
    logic             ovf_q, ovf_nx;
    logic             coef_load;
    logic [width-1:0] n_clamped;

    assign n_clamped = (number_of_erasures > max_n) ? max_n : number_of_erasures;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        n_nx      = n_q;
        k_nx      = k_q;
        idx_nx    = idx_q;
        ovf_nx    = ovf_q;
        coef_load = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    n_nx   = n_clamped;
                    ovf_nx = (number_of_erasures > max_n);
`ifdef ERASURE_LIMIT_CHECK_EN
                    if (n_clamped > no_of_parity) begin
                        state_nx = ST_FAIL;
                    end else begin
                        state_nx = ST_CLEAR;
                    end
`else
                    state_nx = ST_CLEAR;
`endif
                end
            end

            ST_CLEAR: begin
                k_nx     = '0;
                idx_nx   = '0;
                state_nx = (n_q == '0) ? ST_RD_REQ : ST_FETCH;
            end

            ST_FETCH: begin
                state_nx = ST_APPLY;
            end

            ST_APPLY: begin
                k_nx     = k_q + width'(1);
                state_nx = (k_nx == n_q) ? ST_RD_REQ : ST_FETCH;
            end

            ST_RD_REQ: begin
                state_nx = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                if (dp_coef_ready) begin
                    coef_load = 1'b1;
                    state_nx  = ST_OUT;
                end
            end

            ST_OUT: begin
                if (coef_accept) begin
                    idx_nx   = idx_q + width'(1);
                    // Indices 0..N are emitted, so the one matching N is last.
                    state_nx = (idx_q == n_q) ? ST_DONE : ST_RD_REQ;
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
            end

`ifdef ERASURE_LIMIT_CHECK_EN
            ST_FAIL: begin
                state_nx = ST_IDLE;
            end
`endif

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs. Strobes are registered from
    // the next state so each one is high exactly while its state is current.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            n_q              <= '0;
            k_q              <= '0;
            idx_q            <= '0;
            ovf_q            <= 1'b0;
            pos_rd_en        <= 1'b0;
            pos_rd_addr      <= '0;
            dp_clear         <= 1'b0;
            dp_erasure_ready <= 1'b0;
            dp_send_polyn    <= 1'b0;
            dp_coef_addr     <= '0;
            coef_out         <= '0;
            coef_idx         <= '0;
            coef_valid       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_nx;
            n_q              <= n_nx;
            k_q              <= k_nx;
            idx_q            <= idx_nx;
            ovf_q            <= ovf_nx;
            pos_rd_en        <= (state_nx == ST_FETCH);
            pos_rd_addr      <= (state_nx == ST_FETCH) ? k_nx : '0;
            dp_clear         <= (state_nx == ST_CLEAR);
            dp_erasure_ready <= (state_nx == ST_APPLY);
            dp_send_polyn    <= (state_nx == ST_RD_REQ);
            dp_coef_addr     <= (state_nx == ST_RD_REQ) ? idx_nx : '0;
            busy             <= (state_nx != ST_IDLE);
`ifdef ERASURE_LIMIT_CHECK_EN
            // The reject pulse follows the FAIL cycle, two cycles after start.
            done             <= (state_nx == ST_DONE) || (state == ST_FAIL);
`else
            done             <= (state_nx == ST_DONE);
`endif
            if (coef_load) begin
                coef_out   <= dp_coef;
                coef_idx   <= idx_q;
                coef_valid <= 1'b1;
            end else if ((state == ST_OUT) && coef_accept) begin
                coef_valid <= 1'b0;
            end
        end
    end

    assign no_of_erasure_coefs = n_q;
    assign overflow            = ovf_q;

    // Buffer data passes straight through, qualified by the registered step
    // strobe so the bus reads zero outside APPLY and during reset.
    assign dp_erase_position = dp_erasure_ready ? pos_rd_data : 8'h00;

`ifdef ERASURE_LIMIT_CHECK_EN
    logic fail_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= (state == ST_FAIL);
        end
    end

    assign erasure_fail = fail_q;
`else
    // Parity count only matters to the limit check.
    logic unused_parity;
    assign unused_parity = ^no_of_parity;
    assign erasure_fail  = 1'b0;
`endif

endmodule
